// File: rtl/spi_wb_bridge.sv
// SPI-to-Wishbone bridge: resynchronises shift-core bytes into wb_clock_i and turns the
// command / address / data byte stream into pipelined Wishbone read and write cycles.
//
// state     | meaning
// IDLE      | waiting for command byte
// ADDR_HI   | waiting for address[15:8]
// ADDR_LO   | waiting for address[7:0]
// WAIT_DATA | write: waiting for data byte; stream read: waiting for the byte that
//           | consumes the prefetched data before fetching the next one
// WB_REQ    | cyc=stb=1 until the target stops stalling
// WB_ACK    | request accepted, cyc=1 until ack
// DONE      | non-stream transfer finished, bytes ignored until CS deasserts
module spi_wb_bridge #(
    parameter int WB_ADDR_WIDTH = 17,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     wb_clock_i,
    input  logic                     wb_reset_i,
    input  logic                     spi_cs_ni,
    input  logic                     spi_strobe_i,
    input  logic [DATA_WIDTH-1:0]    spi_rx_i,
    output logic [DATA_WIDTH-1:0]    spi_tx_o,
    output logic [WB_ADDR_WIDTH-1:0] wb_addr_o,
    output logic [DATA_WIDTH-1:0]    wb_data_o,
    input  logic [DATA_WIDTH-1:0]    wb_data_i,
    output logic                     wb_we_o,
    output logic                     wb_cyc_o,
    output logic                     wb_stb_o,
    input  logic                     wb_stall_i,
    input  logic                     wb_ack_i,
    output logic                     overrun_o
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ADDR_HI   = 3'd1;
    localparam logic [2:0] S_ADDR_LO   = 3'd2;
    localparam logic [2:0] S_WAIT_DATA = 3'd3;
    localparam logic [2:0] S_WB_REQ    = 3'd4;
    localparam logic [2:0] S_WB_ACK    = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;

    logic [2:0]               state;
    logic                     cs_meta, cs_sync, cs_active_q;
    logic                     strobe_meta, strobe_sync, strobe_q;
    logic [WB_ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0]    data_r;
    logic [DATA_WIDTH-1:0]    tx_r;
    logic                     we_r, stream_r, overrun_r, abort_q;

    logic       cs_active, cs_fall, byte_evt, wb_busy;
    logic [2:0] parse_state;

    assign cs_active   = ~cs_sync;
    assign cs_fall     = cs_active & ~cs_active_q;
    assign byte_evt    = strobe_sync & ~strobe_q;
    assign wb_busy     = (state == S_WB_REQ) || (state == S_WB_ACK);
    // A CS fall coinciding with a byte restarts the parser, so the byte is a command.
    assign parse_state = cs_fall ? S_IDLE : state;

    always_ff @(posedge wb_clock_i) begin
        if (wb_reset_i) begin
            cs_meta     <= 1'b1;
            cs_sync     <= 1'b1;
            cs_active_q <= 1'b0;
            strobe_meta <= 1'b0;
            strobe_sync <= 1'b0;
            strobe_q    <= 1'b0;
            state       <= S_IDLE;
            addr_r      <= '0;
            data_r      <= '0;
            tx_r        <= '0;
            we_r        <= 1'b0;
            stream_r    <= 1'b0;
            overrun_r   <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            cs_meta     <= spi_cs_ni;
            cs_sync     <= cs_meta;
            cs_active_q <= cs_active;
            strobe_meta <= spi_strobe_i;
            strobe_sync <= strobe_meta;
            strobe_q    <= strobe_sync;

            if (cs_fall) overrun_r <= 1'b0;
            if (byte_evt && wb_busy) overrun_r <= 1'b1;

            if (!wb_busy) abort_q <= 1'b0;
            else if (!cs_active) abort_q <= 1'b1;

            case (state)
                S_WB_REQ: begin
                    if (!wb_stall_i) state <= S_WB_ACK;
                end
                S_WB_ACK: begin
                    if (wb_ack_i) begin
                        if (!we_r) tx_r <= wb_data_i;
                        if (abort_q || !cs_active) begin
                            state <= S_IDLE;
                            // CS already re-asserted: the new transaction starts at 0x00.
                            if (cs_active) tx_r <= '0;
                        end else if (stream_r) begin
                            addr_r <= addr_r + WB_ADDR_WIDTH'(1);
                            state  <= S_WAIT_DATA;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                default: begin
                    if (!cs_active) begin
                        state <= S_IDLE;
                    end else begin
                        if (cs_fall) begin
                            tx_r  <= '0;
                            state <= S_IDLE;
                        end
                        if (byte_evt) begin
                            case (parse_state)
                                S_IDLE: begin
                                    we_r     <= spi_rx_i[7];
                                    stream_r <= spi_rx_i[6];
                                    addr_r   <= WB_ADDR_WIDTH'({spi_rx_i[0], 16'h0000});
                                    state    <= S_ADDR_HI;
                                end
                                S_ADDR_HI: begin
                                    addr_r[15:8] <= spi_rx_i;
                                    state        <= S_ADDR_LO;
                                end
                                S_ADDR_LO: begin
                                    addr_r[7:0] <= spi_rx_i;
                                    state       <= we_r ? S_WAIT_DATA : S_WB_REQ;
                                end
                                S_WAIT_DATA: begin
                                    if (we_r) data_r <= spi_rx_i;
                                    state <= S_WB_REQ;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign wb_cyc_o  = wb_busy;
    assign wb_stb_o  = (state == S_WB_REQ);
    assign wb_we_o   = we_r & wb_busy;
    assign wb_addr_o = addr_r;
    assign wb_data_o = data_r;
    assign spi_tx_o  = tx_r;
    assign overrun_o = overrun_r;

endmodule

// File: tb/tb_spi_wb_bridge.sv
// Scoreboard bench for spi_wb_bridge: directed SPI byte streams against a Wishbone
// target model with configurable stall and ack latency.
module tb_spi_wb_bridge;

    logic        wb_clock_i = 1'b0;
    logic        wb_reset_i;
    logic        spi_cs_ni;
    logic        spi_strobe_i;
    logic [7:0]  spi_rx_i;
    logic [7:0]  spi_tx_o;
    logic [16:0] wb_addr_o;
    logic [7:0]  wb_data_o;
    logic [7:0]  wb_data_i;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_stall_i;
    logic        wb_ack_i;
    logic        overrun_o;

    spi_wb_bridge #(.WB_ADDR_WIDTH(17), .DATA_WIDTH(8)) dut (
        .wb_clock_i  (wb_clock_i),
        .wb_reset_i  (wb_reset_i),
        .spi_cs_ni   (spi_cs_ni),
        .spi_strobe_i(spi_strobe_i),
        .spi_rx_i    (spi_rx_i),
        .spi_tx_o    (spi_tx_o),
        .wb_addr_o   (wb_addr_o),
        .wb_data_o   (wb_data_o),
        .wb_data_i   (wb_data_i),
        .wb_we_o     (wb_we_o),
        .wb_cyc_o    (wb_cyc_o),
        .wb_stb_o    (wb_stb_o),
        .wb_stall_i  (wb_stall_i),
        .wb_ack_i    (wb_ack_i),
        .overrun_o   (overrun_o)
    );

    always #5 wb_clock_i = ~wb_clock_i;

    typedef struct {
        logic        we;
        logic [16:0] addr;
        logic [7:0]  data;
    } wb_exp_t;

    wb_exp_t    exp_wb[$];
    logic [7:0] exp_tx[$];
    int         checks = 0;
    int         passes = 0;

    // target model configuration (written by stimulus only)
    int stall_cfg = 0;
    int ack_delay = 1;
    // target model status (written by target only)
    int stall_used = 0;
    int stall_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Wishbone target + transaction monitor
    logic [7:0] mem [0:131071];
    logic [7:0] rd_q;
    int         ack_pend;
    wb_exp_t    mon_e;
    initial begin
        mem[17'h18000] = 8'h11;
        mem[17'h18001] = 8'h22;
        mem[17'h18002] = 8'h33;
        mem[17'h18003] = 8'h44;
        mem[17'h00020] = 8'h5E;
        mem[17'h00030] = 8'h6F;
        mem[17'h00031] = 8'h70;
        rd_q       = 8'h00;
        ack_pend   = 0;
        wb_stall_i = 1'b0;
        wb_ack_i   = 1'b0;
        wb_data_i  = 8'h00;
        forever begin
            @(negedge wb_clock_i);
            wb_ack_i = 1'b0;
            if (ack_pend > 0) begin
                ack_pend--;
                if (ack_pend == 0) begin
                    wb_ack_i  = 1'b1;
                    wb_data_i = rd_q;
                end
            end else if (wb_cyc_o && wb_stb_o) begin
                if (stall_used < stall_cfg) begin
                    wb_stall_i = 1'b1;
                    stall_used++;
                    stall_seen++;
                end else begin
                    wb_stall_i = 1'b0;
                    stall_used = 0;
                    if (exp_wb.size() == 0) begin
                        checks++;
                        $display("FAIL wb_unexpected: got we=%0d addr=%05h data=%02h expected no cycle",
                                 wb_we_o, wb_addr_o, wb_data_o);
                    end else begin
                        mon_e = exp_wb.pop_front();
                        check("wb_we", {31'd0, wb_we_o}, {31'd0, mon_e.we});
                        check("wb_addr", {15'd0, wb_addr_o}, {15'd0, mon_e.addr});
                        if (mon_e.we) check("wb_data", {24'd0, wb_data_o}, {24'd0, mon_e.data});
                    end
                    if (wb_we_o) mem[wb_addr_o] = wb_data_o;
                    else rd_q = mem[wb_addr_o];
                    ack_pend = ack_delay;
                end
            end else begin
                wb_stall_i = 1'b0;
            end
        end
    end

    // MISO monitor: the byte the shift core loads at the start of each SPI byte
    logic [7:0] tx_e;
    always @(negedge wb_clock_i) begin
        if (exp_tx.size() > 0) begin
            tx_e = exp_tx.pop_front();
            check("spi_tx", {24'd0, spi_tx_o}, {24'd0, tx_e});
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic [7:0] tx_exp, input int hi, input int lo);
        @(posedge wb_clock_i); #1;
        exp_tx.push_back(tx_exp);
        spi_rx_i     = b;
        spi_strobe_i = 1'b1;
        repeat (hi) @(posedge wb_clock_i);
        #1 spi_strobe_i = 1'b0;
        repeat (lo) @(posedge wb_clock_i);
    endtask

    task automatic cs_set(input logic v);
        @(posedge wb_clock_i); #1;
        spi_cs_ni = v;
        repeat (4) @(posedge wb_clock_i);
    endtask

    task automatic push_wb(input logic we, input logic [16:0] addr, input logic [7:0] data);
        wb_exp_t e;
        e.we = we; e.addr = addr; e.data = data;
        exp_wb.push_back(e);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int base;
        wb_reset_i   = 1'b1;
        spi_cs_ni    = 1'b1;
        spi_strobe_i = 1'b0;
        spi_rx_i     = 8'h00;
        repeat (3) @(posedge wb_clock_i);
        #1 wb_reset_i = 1'b0;
        check("rst_cyc", {31'd0, wb_cyc_o}, 0);
        check("rst_stb", {31'd0, wb_stb_o}, 0);
        check("rst_we", {31'd0, wb_we_o}, 0);
        check("rst_addr", {15'd0, wb_addr_o}, 0);
        check("rst_data", {24'd0, wb_data_o}, 0);
        check("rst_tx", {24'd0, spi_tx_o}, 0);
        check("rst_overrun", {31'd0, overrun_o}, 0);

        // single write
        cs_set(1'b0);
        push_wb(1'b1, 17'h01234, 8'hAB);
        send_byte(8'h80, 8'h00, 4, 28);
        send_byte(8'h12, 8'h00, 4, 28);
        send_byte(8'h34, 8'h00, 4, 28);
        send_byte(8'hAB, 8'h00, 4, 28);
        cs_set(1'b1);

        // streaming read with prefetch
        cs_set(1'b0);
        push_wb(1'b0, 17'h18000, 8'h00);
        push_wb(1'b0, 17'h18001, 8'h00);
        push_wb(1'b0, 17'h18002, 8'h00);
        push_wb(1'b0, 17'h18003, 8'h00);
        send_byte(8'h41, 8'h00, 4, 28);
        send_byte(8'h80, 8'h00, 4, 28);
        send_byte(8'h00, 8'h00, 4, 28);
        send_byte(8'hFF, 8'h11, 4, 28);
        send_byte(8'hFF, 8'h22, 4, 28);
        send_byte(8'hFF, 8'h33, 4, 28);
        cs_set(1'b1);

        // streaming write across the address wrap
        cs_set(1'b0);
        push_wb(1'b1, 17'h1FFFF, 8'h5A);
        push_wb(1'b1, 17'h00000, 8'hA5);
        send_byte(8'hC1, 8'h00, 4, 28);
        send_byte(8'hFF, 8'h00, 4, 28);
        send_byte(8'hFF, 8'h00, 4, 28);
        send_byte(8'h5A, 8'h00, 4, 28);
        send_byte(8'hA5, 8'h00, 4, 28);
        cs_set(1'b1);

        // stalled, late-acked write with a byte arriving mid-cycle
        stall_cfg = 3;
        ack_delay = 5;
        base = stall_seen;
        cs_set(1'b0);
        push_wb(1'b1, 17'h00010, 8'h77);
        send_byte(8'h80, 8'h00, 4, 28);
        send_byte(8'h00, 8'h00, 4, 28);
        send_byte(8'h10, 8'h00, 4, 28);
        send_byte(8'h77, 8'h00, 2, 2);
        send_byte(8'h99, 8'h00, 4, 28);
        check("overrun_set", {31'd0, overrun_o}, 1);
        check("stall_cycles", stall_seen - base, 3);
        send_byte(8'h55, 8'h00, 4, 28);
        stall_cfg = 0;
        cs_set(1'b1);
        check("overrun_held", {31'd0, overrun_o}, 1);
        cs_set(1'b0);
        check("overrun_clear", {31'd0, overrun_o}, 0);
        cs_set(1'b1);

        // CS deasserted while waiting for ack
        ack_delay = 20;
        cs_set(1'b0);
        push_wb(1'b0, 17'h00020, 8'h00);
        send_byte(8'h00, 8'h00, 4, 28);
        send_byte(8'h00, 8'h00, 4, 28);
        send_byte(8'h20, 8'h00, 4, 2);
        cs_set(1'b1);
        check("cyc_held", {31'd0, wb_cyc_o}, 1);
        n = 0;
        while (wb_cyc_o && n < 60) begin
            @(posedge wb_clock_i); #1;
            n++;
        end
        check("cyc_release", {31'd0, wb_cyc_o}, 0);
        check("tx_after_abort", {24'd0, spi_tx_o}, 32'h5E);
        ack_delay = 1;

        // new stream read after the abort, then reset while stalled in WB_REQ
        cs_set(1'b0);
        push_wb(1'b0, 17'h00030, 8'h00);
        send_byte(8'h40, 8'h00, 4, 28);
        send_byte(8'h00, 8'h00, 4, 28);
        send_byte(8'h30, 8'h00, 4, 28);
        stall_cfg = 1000;
        send_byte(8'hFF, 8'h6F, 4, 2);
        repeat (2) @(posedge wb_clock_i);
        #1 check("stb_before_reset", {31'd0, wb_stb_o}, 1);
        @(posedge wb_clock_i); #1 wb_reset_i = 1'b1;
        @(posedge wb_clock_i); #1 wb_reset_i = 1'b0;
        check("reset_cyc", {31'd0, wb_cyc_o}, 0);
        check("reset_stb", {31'd0, wb_stb_o}, 0);
        check("reset_tx", {24'd0, spi_tx_o}, 0);
        check("reset_addr", {15'd0, wb_addr_o}, 0);
        stall_cfg = 0;
        repeat (4) @(posedge wb_clock_i);

        // parser is back in IDLE: a fresh command works with CS still low
        push_wb(1'b1, 17'h00050, 8'h3C);
        send_byte(8'h80, 8'h00, 4, 28);
        send_byte(8'h00, 8'h00, 4, 28);
        send_byte(8'h50, 8'h00, 4, 28);
        send_byte(8'h3C, 8'h00, 4, 28);
        cs_set(1'b1);

        repeat (40) @(posedge wb_clock_i);
        check("wb_queue_left", exp_wb.size(), 0);
        check("tx_queue_left", exp_tx.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
